wb_initiator: RTL and testbench
===============================

// Module: wb_initiator
// PURPOSE
// - Single-outstanding Wishbone classic master: turns a core-side valid/ready request into one
//   Wishbone cycle, waits for ack/err/timeout, returns one response pulse.
// - Initiator counterpart of the wb_ram responder; sits between naive_soc-side agents
//   (DMA, debug bridge) and the board RAM/peripheral bus. All wb_* outputs registered.
// PARAMETERS
// - TIMEOUT   256  cycles with cyc/stb high and no ack/err before abort; 0 = never time out
// - ERR_DATA  32'hDEAD_BEEF  rsp_rdata value returned on err/timeout
// PORTS
// - clk        in   1   clock; all logic on posedge
// - reset      in   1   asynchronous, active-high
// - req_valid  in   1   request present
// - req_ready  out  1   high only in IDLE; request accepted when req_valid & req_ready
// - req_we     in   1   1 = write, 0 = read
// - req_addr   in   32  byte address; bits [1:0] ignored (forced 0 on bus)
// - req_wdata  in   32  write data
// - req_sel    in   4   byte lanes; 4'b0000 is promoted to 4'b1111
// - rsp_valid  out  1   one-cycle response pulse
// - rsp_rdata  out  32  read data (writes: 0; err/timeout: ERR_DATA); held until next response
// - rsp_err    out  1   qualifies rsp_valid: 1 = bus error or timeout
// - wb_addr    out  32  Wishbone address
// - wb_wdata   out  32  Wishbone write data
// - wb_sel     out  4   Wishbone byte select
// - wb_we      out  1   Wishbone write enable
// - wb_cyc     out  1   Wishbone cycle
// - wb_stb     out  1   Wishbone strobe (always equal to wb_cyc)
// - wb_rdata   in   32  Wishbone read data, valid when wb_ack
// - wb_ack     in   1   Wishbone acknowledge
// - wb_err     in   1   Wishbone error (tie 0 if slave has none)
// BEHAVIOUR
// - Reset (async): state IDLE; wb_cyc/wb_stb/wb_we=0, wb_addr/wb_wdata=0, wb_sel=0,
//   rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout counter=0. Mid-cycle reset drops cyc/stb at once.
// - FSM IDLE -> BUS -> RESP -> IDLE.
// - IDLE: req_ready=1. On req_valid: latch we/addr/wdata/sel into wb_* regs, set cyc=stb=1,
//   clear counter, go BUS. wb_* fields only change on acceptance.
// - BUS: req_ready=0; cyc/stb held high, all wb_* stable. Each cycle sample:
//   wb_err -> error; else wb_ack -> success; else counter==TIMEOUT-1 (TIMEOUT>0) -> timeout;
//   else counter+1 (saturating width $clog2(TIMEOUT+1)). On any terminator: cyc=stb=we=0
//   on that same edge (slave sees exactly one ack cycle), go RESP.
// - Priority when simultaneous: err > ack > timeout.
// - Success read: rsp_rdata <= wb_rdata captured at ack edge; success write: rsp_rdata <= 0.
// - RESP: rsp_valid=1, rsp_err per terminator, for exactly one cycle; req_ready=0; -> IDLE.
//   Next request acceptable the cycle after RESP (min 3 cycles/transaction).
// - wb_ack/wb_err while in IDLE or RESP are ignored (no response generated).
// - Latency vs wb_ram (ack 2 cycles after stb): accept edge T, ack sampled T+3,
//   rsp_valid high cycle T+3..T+4.
// TESTING
// - Read: accept {addr=0x10,we=0,sel=F}; slave acks 2 cycles later with 0x1234_5678 ->
//   wb_addr=0x10 during cycle, one rsp_valid, rsp_rdata=0x1234_5678, rsp_err=0, cyc low after ack.
// - Write addr=0x13 sel=0 wdata=0xA5A5_0F0F -> wb_addr=0x10, wb_sel=F, wb_we=1; ack ->
//   rsp_valid, rsp_err=0, rsp_rdata=0; wb_ram read-back returns 0xA5A5_0F0F.
// - Timeout (TIMEOUT=8, slave never acks) -> cyc high exactly 8 cycles, then rsp_err=1,
//   rsp_rdata=0xDEAD_BEEF; req_ready back 1 next cycle.
// - wb_ack and wb_err same cycle -> rsp_err=1; ack on timeout cycle -> success, rsp_err=0.
// - Back-to-back: req_valid held with 4 queued requests -> 4 bus cycles, 4 responses in order,
//   no request lost/duplicated, req_ready low from accept through RESP.
// - Assert reset while in BUS -> wb_cyc/wb_stb=0 immediately, no rsp_valid; after release
//   req_ready=1 and a fresh read completes normally.

Source files
------------

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Purpose  : Single-outstanding Wishbone classic master. Converts one
//            core-side valid/ready request into one Wishbone cycle, waits
//            for ack, err or a timeout, then returns a one-cycle response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, all logic on posedge
//   reset      in   1   asynchronous, active-high
//   req_valid  in   1   request present
//   req_ready  out  1   high only in IDLE
//   req_we     in   1   1 = write, 0 = read
//   req_addr   in   32  byte address, bits [1:0] forced to 0 on the bus
//   req_wdata  in   32  write data
//   req_sel    in   4   byte lanes, 4'b0000 promoted to 4'b1111
//   rsp_valid  out  1   one-cycle response pulse
//   rsp_rdata  out  32  read data / 0 for writes / ERR_DATA on err or timeout
//   rsp_err    out  1   1 = bus error or timeout
//   wb_addr    out  32  Wishbone address
//   wb_wdata   out  32  Wishbone write data
//   wb_sel     out  4   Wishbone byte select
//   wb_we      out  1   Wishbone write enable
//   wb_cyc     out  1   Wishbone cycle
//   wb_stb     out  1   Wishbone strobe, always equal to wb_cyc
//   wb_rdata   in   32  Wishbone read data, valid with wb_ack
//   wb_ack     in   1   Wishbone acknowledge
//   wb_err     in   1   Wishbone error
// ============================================================================
module wb_initiator #(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_wdata,
    output logic [3:0]  wb_sel,
    output logic        wb_we,
    output logic        wb_cyc,
    output logic        wb_stb,
    input  logic [31:0] wb_rdata,
    input  logic        wb_ack,
    input  logic        wb_err
);

    // Counter is wide enough to hold TIMEOUT; a disabled timeout still
    // needs a legal one-bit vector.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] c_CNT_MAX  = '1;
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic          w_timeout;
    logic          w_term;
    logic          w_fail;

    assign w_timeout = (TIMEOUT > 0) && (r_count == c_CNT_LAST);
    assign w_term    = wb_err | wb_ack | w_timeout;
    // err beats ack, ack beats timeout: only a clean ack is a success.
    assign w_fail    = wb_err | ~wb_ack;

    assign req_ready = (r_state == c_ST_IDLE);
    assign wb_stb    = wb_cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_ST_IDLE;
            r_count   <= '0;
            wb_cyc    <= 1'b0;
            wb_we     <= 1'b0;
            wb_addr   <= 32'h0;
            wb_wdata  <= 32'h0;
            wb_sel    <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        wb_we    <= req_we;
                        wb_addr  <= req_addr & 32'hFFFF_FFFC;
                        wb_wdata <= req_wdata;
                        wb_sel   <= (req_sel == 4'h0) ? 4'hF : req_sel;
                        wb_cyc   <= 1'b1;
                        r_count  <= '0;
                        r_state  <= c_ST_BUS;
                    end
                end
                c_ST_BUS: begin
                    if (w_term) begin
                        // Drop the cycle on the terminating edge so the
                        // slave sees exactly one ack cycle.
                        wb_cyc    <= 1'b0;
                        wb_we     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= w_fail;
                        if (w_fail) begin
                            rsp_rdata <= ERR_DATA;
                        end else if (wb_we) begin
                            rsp_rdata <= 32'h0;
                        end else begin
                            rsp_rdata <= wb_rdata;
                        end
                        r_state <= c_ST_RESP;
                    end else if (r_count != c_CNT_MAX) begin
                        r_count <= r_count + c_CNT_ONE;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Purpose  : Self-checking bench for wb_initiator with a behavioural slave
//            memory and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_sel = 4'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] wb_addr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdata = 32'h0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    wb_initiator #(.TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_rdata(wb_rdata),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Request script: ack/err given as the bus cycle number (1 = first
    // cycle with cyc high) on which the slave asserts it; 0 = never.
    logic        q_we    [64];
    logic [31:0] q_addr  [64];
    logic [31:0] q_wdata [64];
    logic [3:0]  q_sel   [64];
    int          q_ack   [64];
    int          q_err   [64];

    logic        o_err   [64];
    logic [31:0] o_rdata [64];
    logic [31:0] o_addr  [64];
    logic [31:0] o_wdata [64];
    logic [3:0]  o_sel   [64];
    logic        o_we    [64];
    int          o_len   [64];
    bit          o_unst  [64];
    int          nrsp;
    int          viol;

    logic        e_err   [64];
    logic [31:0] e_rdata [64];
    int          e_len   [64];

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a] = v;
        slv_mem[a] = v;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input int ack_at, input int err_at);
        q_we[i] = we; q_addr[i] = a; q_wdata[i] = d; q_sel[i] = s;
        q_ack[i] = ack_at; q_err[i] = err_at;
    endtask

    // Reference model: the earliest of ack, err or the timeout ends the
    // cycle; err wins ties, a lone ack is success, otherwise it failed.
    task automatic build_expected(input int n);
        for (int i = 0; i < n; i++) begin
            int term = TO;
            logic [31:0] a = {q_addr[i][31:2], 2'b00};
            if (q_ack[i] > 0 && q_ack[i] < term) term = q_ack[i];
            if (q_err[i] > 0 && q_err[i] <= term) term = q_err[i];
            e_len[i] = term;
            if (q_err[i] == term || q_ack[i] != term) begin
                e_err[i] = 1'b1; e_rdata[i] = 32'hDEAD_BEEF;
            end else begin
                e_err[i] = 1'b0;
                if (q_we[i]) begin
                    ref_mem[a] = merge(rd_ref(a), q_wdata[i], (q_sel[i] == 4'h0) ? 4'hF : q_sel[i]);
                    e_rdata[i] = 32'h0;
                end else begin
                    e_rdata[i] = rd_ref(a);
                end
            end
        end
    endtask

    // Drives the scripted requests, plays the slave, records what the bus
    // and response ports show, and counts protocol violations.
    task automatic run_seq(input int n, input bit gap);
        int idx = 0;
        int cur = 0;
        int run = 0;
        bit acc = 1'b0;
        bit prev_rsp = 1'b0;
        logic [31:0] prev_rd;
        nrsp = 0; viol = 0;
        prev_rd = rsp_rdata;
        for (int i = 0; i < n; i++) begin
            o_err[i] = 1'bx; o_rdata[i] = 'x; o_len[i] = -1; o_unst[i] = 1'b0;
        end
        for (int c = 0; c < 60 * n + 40 && (nrsp < n || cur < n); c++) begin
            @(negedge clk);
            if (wb_stb !== wb_cyc) viol++;
            if (req_ready && (wb_cyc || rsp_valid)) viol++;
            if (!wb_cyc && wb_we) viol++;
            if (prev_rsp && (rsp_valid || !req_ready)) viol++;
            if (!rsp_valid && rsp_rdata !== prev_rd) viol++;
            prev_rsp = rsp_valid;
            prev_rd  = rsp_rdata;
            if (!wb_cyc && run > 0) begin
                if (cur < 64) o_len[cur] = run;
                run = 0; cur++;
            end
            if (rsp_valid) begin
                if (nrsp < 64) begin o_err[nrsp] = rsp_err; o_rdata[nrsp] = rsp_rdata; end
                nrsp++;
            end
            wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = $urandom;
            if (wb_cyc && cur < n) begin
                run++;
                if (run == 1) begin
                    o_addr[cur] = wb_addr; o_wdata[cur] = wb_wdata;
                    o_sel[cur] = wb_sel; o_we[cur] = wb_we;
                end else if ({wb_addr, wb_wdata, wb_sel, wb_we} !==
                             {o_addr[cur], o_wdata[cur], o_sel[cur], o_we[cur]}) begin
                    o_unst[cur] = 1'b1;
                end
                wb_err = (q_err[cur] == run);
                wb_ack = (q_ack[cur] == run);
                if (wb_ack && !wb_err) begin
                    if (wb_we) slv_mem[wb_addr] = merge(rd_slv(wb_addr), wb_wdata, wb_sel);
                    else wb_rdata = rd_slv(wb_addr);
                end
            end else if (gap) begin
                // Stray handshakes outside a cycle must be ignored.
                wb_ack = ($urandom_range(0, 3) == 0);
                wb_err = ($urandom_range(0, 5) == 0);
            end
            if (acc) idx++;
            req_valid = (idx < n) && (!gap || $urandom_range(0, 2) != 0);
            if (idx < n) begin
                req_we = q_we[idx]; req_addr = q_addr[idx];
                req_wdata = q_wdata[idx]; req_sel = q_sel[idx];
            end
            acc = req_valid && req_ready;
        end
        req_valid = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        @(negedge clk);
        if (rsp_valid || !req_ready) viol++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin
            fails++; $display("FAIL reset_ctrl got cyc/stb/we=%b want 000", {wb_cyc, wb_stb, wb_we});
        end
        tests++;
        if ({wb_addr, wb_wdata, wb_sel} !== 68'h0) begin
            fails++; $display("FAIL reset_bus got addr=%h wdata=%h sel=%h want zeros", wb_addr, wb_wdata, wb_sel);
        end
        tests++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            fails++; $display("FAIL reset_rsp got valid=%b err=%b rdata=%h want zeros", rsp_valid, rsp_err, rsp_rdata);
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_write();
        preload(32'h10, 32'h1234_5678);
        set_req(0, 1'b0, 32'h10, 32'h0BAD_0001, 4'hF, 2, 0);
        set_req(1, 1'b1, 32'h13, 32'hA5A5_0F0F, 4'h0, 2, 0);
        set_req(2, 1'b0, 32'h10, 32'h0BAD_0002, 4'hF, 2, 0);
        build_expected(3);
        run_seq(3, 1'b1);
        tests++;
        if (nrsp !== 3) begin fails++; $display("FAIL rw_count got %0d want 3", nrsp); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (o_err[i] !== e_err[i] || o_rdata[i] !== e_rdata[i]) begin
                fails++; $display("FAIL rw_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h",
                                  i, o_err[i], o_rdata[i], e_err[i], e_rdata[i]);
            end
            tests++;
            if (o_len[i] !== e_len[i]) begin
                fails++; $display("FAIL rw_cyc_len[%0d] got %0d want %0d", i, o_len[i], e_len[i]);
            end
            tests++;
            if ({o_addr[i], o_wdata[i], o_sel[i], o_we[i], o_unst[i]} !==
                {q_addr[i] & 32'hFFFF_FFFC, q_wdata[i], (q_sel[i] == 4'h0) ? 4'hF : q_sel[i], q_we[i], 1'b0}) begin
                fails++; $display("FAIL rw_bus[%0d] got addr=%h sel=%h we=%b unstable=%b", i, o_addr[i], o_sel[i], o_we[i], o_unst[i]);
            end
        end
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL rw_protocol got %0d violations want 0", viol); end
    endtask

    task automatic test_timeout_priority();
        preload(32'h24, 32'h2424_2424);
        preload(32'h28, 32'h2828_2828);
        set_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 0);   // no answer: timeout
        set_req(1, 1'b0, 32'h24, 32'h0, 4'hF, 3, 3);   // ack and err together
        set_req(2, 1'b0, 32'h28, 32'h0, 4'hF, TO, 0);  // ack on the timeout cycle
        set_req(3, 1'b1, 32'h30, 32'h1, 4'h3, 0, 2);   // plain error on a write
        build_expected(4);
        run_seq(4, 1'b0);
        tests++;
        if (nrsp !== 4) begin fails++; $display("FAIL to_count got %0d want 4", nrsp); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (o_err[i] !== e_err[i] || o_rdata[i] !== e_rdata[i]) begin
                fails++; $display("FAIL to_rsp[%0d] got err=%b rdata=%h want err=%b rdata=%h",
                                  i, o_err[i], o_rdata[i], e_err[i], e_rdata[i]);
            end
            tests++;
            if (o_len[i] !== e_len[i]) begin
                fails++; $display("FAIL to_cyc_len[%0d] got %0d want %0d", i, o_len[i], e_len[i]);
            end
        end
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL to_protocol got %0d violations want 0", viol); end
    endtask

    task automatic test_back_to_back(input int n, input bit gap, input bit errs);
        for (int i = 0; i < n; i++) begin
            set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                    4'($urandom_range(0, 15)),
                    errs ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 4)),
                    (errs && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0);
        end
        build_expected(n);
        run_seq(n, gap);
        tests++;
        if (nrsp !== n) begin fails++; $display("FAIL seq_count got %0d want %0d", nrsp, n); end
        for (int i = 0; i < n; i++) begin
            tests++;
            if (o_err[i] !== e_err[i] || o_rdata[i] !== e_rdata[i] || o_len[i] !== e_len[i]) begin
                fails++; $display("FAIL seq_rsp[%0d] got err=%b rdata=%h len=%0d want err=%b rdata=%h len=%0d",
                                  i, o_err[i], o_rdata[i], o_len[i], e_err[i], e_rdata[i], e_len[i]);
            end
            tests++;
            if ({o_addr[i], o_wdata[i], o_sel[i], o_we[i], o_unst[i]} !==
                {q_addr[i] & 32'hFFFF_FFFC, q_wdata[i], (q_sel[i] == 4'h0) ? 4'hF : q_sel[i], q_we[i], 1'b0}) begin
                fails++; $display("FAIL seq_bus[%0d] got addr=%h sel=%h we=%b unstable=%b", i, o_addr[i], o_sel[i], o_we[i], o_unst[i]);
            end
        end
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL seq_protocol got %0d violations want 0", viol); end
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        int rsp_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_sel = 4'hF;
        wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wb_cyc) seen++;
        end
        tests++;
        if (seen !== 4) begin fails++; $display("FAIL mrst_bus got %0d cyc cycles want 4", seen); end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({wb_cyc, wb_stb} !== 2'b00) begin
            fails++; $display("FAIL mrst_async got cyc/stb=%b want 00", {wb_cyc, wb_stb});
        end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc) rsp_seen++;
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        tests++;
        if (rsp_seen !== 0) begin fails++; $display("FAIL mrst_quiet got %0d stray cycles want 0", rsp_seen); end
        tests++;
        if (req_ready !== 1'b1) begin fails++; $display("FAIL mrst_ready got %b want 1", req_ready); end
        preload(32'h48, 32'hC0DE_0048);
        set_req(0, 1'b0, 32'h48, 32'h0, 4'hF, 2, 0);
        build_expected(1);
        run_seq(1, 1'b0);
        tests++;
        if (nrsp !== 1 || o_err[0] !== e_err[0] || o_rdata[0] !== e_rdata[0]) begin
            fails++; $display("FAIL mrst_read got n=%0d err=%b rdata=%h want n=1 err=%b rdata=%h",
                              nrsp, o_err[0], o_rdata[0], e_err[0], e_rdata[0]);
        end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_timeout_priority();
        test_back_to_back(4, 1'b0, 1'b0);
        for (int a = 0; a < 64; a += 4) preload(32'(a), $urandom);
        test_back_to_back(40, 1'b1, 1'b1);
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
